multicycle_stage_sequencer: RTL and testbench
=============================================

Name: multicycle_stage_sequencer

Overview:
- Multi-cycle CPU control stage that generates `stage` and `PC_value` for the dual-port main memory controller directly downstream of it.
- Latches the fetched instruction from read port 0.
- Sequences FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK, inserting wait cycles for memory latency.
- Skips MEMORY for non-memory instructions; parks in HALTED on a halt instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_LATENCY, 1, cycles from address presentation to valid read data (legal range 1..7).
- PC_STEP, 4, PC increment for sequential flow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  freezes stage, wait counter, PC and IR while high.
- read_data_0  input  32  instruction word returned on memory read port 0.
- current_instr_type  input  5  decoded type of instruction_reg, from decoder.
- branch_taken  input  1  sampled in WRITEBACK; selects branch_target.
- branch_target  input  32  next PC when branch_taken.
- stage  output  `STAGE_WIDTH  current stage code.
- PC_value  output  32  current PC; drives read port 0 address.
- instruction_reg  output  32  latched instruction.
- retire  output  1  one-cycle pulse when an instruction completes WRITEBACK.
- halted  output  1  high while in HALTED.
- retired_count  output  32  number of retired instructions.

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high. All state clears immediately on rst assertion:
  - stage=`STAGE_FETCH, PC_value=RESET_PC, instruction_reg=0, retire=0, halted=0, retired_count=0, wait counter=0.
- States:
  - FETCH: PC_value is stable. Wait counter counts 0..MEM_LATENCY-1. On the cycle counter==MEM_LATENCY-1, instruction_reg<=read_data_0 and next state is DECODE. FETCH lasts exactly MEM_LATENCY cycles.
  - DECODE: 1 cycle. If current_instr_type==`INSTR_HALT → HALTED; otherwise → EXECUTE.
  - EXECUTE: 1 cycle. If type is `INSTR_LOAD or `INSTR_STORE → MEMORY; otherwise → WRITEBACK.
  - MEMORY: lasts MEM_LATENCY cycles (same counter scheme), then → WRITEBACK. The store write enable is produced downstream from stage==`STAGE_MEMORY.
  - WRITEBACK: 1 cycle.
    - PC_value<=branch_taken ? branch_target : PC_value+PC_STEP, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
    - retire=1 for this cycle only; retired_count increments, wrapping at 2^32.
    - Next state is FETCH.
  - HALTED: absorbing. Only rst exits. PC and IR hold. halted=1.
- Wait counter: 3 bits; cleared on entry to FETCH and MEMORY.
- stall:
  - Sampled every cycle. When high, no register updates: state, counter, PC, IR and count all hold, and retire=0 even in WRITEBACK.
  - The retire pulse fires on the first non-stalled WRITEBACK cycle.
  - stall in HALTED has no effect.
- Inputs are sampled only in their owning stage:
  - current_instr_type: DECODE and EXECUTE.
  - branch_*: WRITEBACK.
  - read_data_0: last FETCH cycle.
- All outputs are registered except `stage`, which is the state register itself. No combinational paths from inputs to outputs.
- Reset mid-instruction abandons it: no retire, no PC update. The first FETCH after deassertion begins at RESET_PC.
- An unknown stage encoding recovers to FETCH.

Decomposition:
- arch_defines gains:
  - `STAGE_FETCH, `STAGE_DECODE, `STAGE_EXECUTE, `STAGE_MEMORY, `STAGE_WRITEBACK, `STAGE_HALTED
  - `STAGE_WIDTH as [2:0]
  - `INSTR_LOAD, `INSTR_HALT alongside the existing `INSTR_STORE.
- One sub-module, pc_register: holds PC with reset value, enable and branch-select inputs. The sequencer FSM, wait counter and IR latch stay in the top module.

Test Plan:
- Reset then release, MEM_LATENCY=1, type=ALU, no branch:
  - stage sequence is FETCH, DECODE, EXECUTE, WRITEBACK, FETCH.
  - PC 0→4; retire pulses once; retired_count=1.
- MEM_LATENCY=3, read_data_0=32'hDEAD_BEEF presented only on the 3rd FETCH cycle → instruction_reg=32'hDEAD_BEEF; FETCH lasts 3 cycles.
- type=`INSTR_STORE, MEM_LATENCY=2 → MEMORY held 2 cycles, then WRITEBACK; total instruction = 2+1+1+2+1 = 7 cycles.
- branch_taken=1, branch_target=32'h100 in WRITEBACK → next FETCH has PC_value=32'h100. RESET_PC=32'hFFFF_FFFC with no branch → PC wraps to 0.
- stall high for 5 cycles during WRITEBACK → stage, PC and count frozen with no retire; the pulse appears on the first cycle after stall drops.
- `INSTR_HALT in DECODE:
  - Enters HALTED, halted=1, PC frozen for 20 cycles.
  - Async rst pulsed mid-cycle → immediate FETCH with PC=RESET_PC.
  - Also repeat rst during MEMORY → no retire, count unchanged.

Source files
------------

// File: rtl/multicycle_stage_sequencer_pkg.sv
// Shared definitions for the multi-cycle stage sequencer.
// Holds the stage codes presented to the downstream memory controller, the instruction type
// codes produced by the decoder, and a helper that classifies memory instructions.
package multicycle_stage_sequencer_pkg;

  localparam int unsigned STAGE_WIDTH = 3;
  localparam int unsigned ITYPE_WIDTH = 5;

  typedef logic [STAGE_WIDTH-1:0] stage_t;
  typedef logic [ITYPE_WIDTH-1:0] itype_t;

  // Stage codes; 3'd6 and 3'd7 are unused and recover to FETCH.
  localparam stage_t STAGE_FETCH     = 3'd0;
  localparam stage_t STAGE_DECODE    = 3'd1;
  localparam stage_t STAGE_EXECUTE   = 3'd2;
  localparam stage_t STAGE_MEMORY    = 3'd3;
  localparam stage_t STAGE_WRITEBACK = 3'd4;
  localparam stage_t STAGE_HALTED    = 3'd5;

  // Decoder instruction type codes.
  localparam itype_t INSTR_ALU    = 5'h00;
  localparam itype_t INSTR_LOAD   = 5'h01;
  localparam itype_t INSTR_STORE  = 5'h02;
  localparam itype_t INSTR_BRANCH = 5'h03;
  localparam itype_t INSTR_HALT   = 5'h1F;

  function automatic logic is_mem_instr(itype_t t);
    return (t == INSTR_LOAD) || (t == INSTR_STORE);
  endfunction

endpackage

// File: rtl/multicycle_stage_sequencer_if.sv
// Bus between the stage sequencer and its environment (memory controller, decoder, branch unit).
//   master : the sequencer; drives stage, PC_value, instruction_reg, retire, halted,
//            retired_count; receives stall, read_data_0, current_instr_type, branch_*.
//   slave  : the environment side of the same signals.
interface multicycle_stage_sequencer_if;
  import multicycle_stage_sequencer_pkg::*;

  logic        stall;
  logic [31:0] read_data_0;
  itype_t      current_instr_type;
  logic        branch_taken;
  logic [31:0] branch_target;

  stage_t      stage;
  logic [31:0] PC_value;
  logic [31:0] instruction_reg;
  logic        retire;
  logic        halted;
  logic [31:0] retired_count;

  modport master (
    input  stall, read_data_0, current_instr_type, branch_taken, branch_target,
    output stage, PC_value, instruction_reg, retire, halted, retired_count
  );

  modport slave (
    output stall, read_data_0, current_instr_type, branch_taken, branch_target,
    input  stage, PC_value, instruction_reg, retire, halted, retired_count
  );

endinterface

// File: rtl/multicycle_stage_sequencer_pc_register.sv
// Program counter register.
//   clk, rst  : clock and asynchronous active-high reset (loads RESET_PC).
//   en_i      : advance the PC this cycle (one cycle per retired instruction).
//   branch_i  : when advancing, take target_i instead of the sequential step.
//   target_i  : branch destination.
//   pc_o      : current PC.
module multicycle_stage_sequencer_pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        branch_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  // Sequential step wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (en_i) begin
      pc_d = branch_i ? target_i : pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// Multi-cycle CPU control stage. Steps FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK,
// holding FETCH and MEMORY for MEM_LATENCY cycles, and parks in HALTED on a halt instruction.
//   clk, rst : clock and asynchronous active-high reset.
//   bus      : master side of multicycle_stage_sequencer_if (see that file for signals).
// All outputs are registers; stage is the state register itself. retire, retired_count and
// the new PC all become visible together, right after the non-stalled WRITEBACK edge.
module multicycle_stage_sequencer
  import multicycle_stage_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] PC_STEP     = 32'd4
) (
  input logic                          clk,
  input logic                          rst,
  multicycle_stage_sequencer_if.master bus
);

  // Counter value on the final cycle of a FETCH or MEMORY wait.
  localparam logic [2:0] LastWait = 3'(MEM_LATENCY - 1);

  stage_t      stage_q, stage_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] count_q, count_d;
  logic        retire_q, retire_d;
  logic        halted_q, halted_d;
  logic        pc_en;
  logic        advance;

  assign advance = ~bus.stall;

  always_comb begin
    stage_d  = stage_q;
    wait_d   = wait_q;
    ir_d     = ir_q;
    count_d  = count_q;
    retire_d = 1'b0;
    halted_d = halted_q;
    pc_en    = 1'b0;
    case (stage_q)
      STAGE_FETCH: begin
        if (advance) begin
          if (wait_q == LastWait) begin
            ir_d    = bus.read_data_0;
            wait_d  = 3'd0;
            stage_d = STAGE_DECODE;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
      end
      STAGE_DECODE: begin
        if (advance) begin
          if (bus.current_instr_type == INSTR_HALT) begin
            stage_d  = STAGE_HALTED;
            halted_d = 1'b1;
          end else begin
            stage_d = STAGE_EXECUTE;
          end
        end
      end
      STAGE_EXECUTE: begin
        if (advance) begin
          wait_d  = 3'd0;
          stage_d = is_mem_instr(bus.current_instr_type) ? STAGE_MEMORY : STAGE_WRITEBACK;
        end
      end
      STAGE_MEMORY: begin
        if (advance) begin
          if (wait_q == LastWait) begin
            wait_d  = 3'd0;
            stage_d = STAGE_WRITEBACK;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
      end
      STAGE_WRITEBACK: begin
        if (advance) begin
          pc_en    = 1'b1;
          retire_d = 1'b1;
          count_d  = count_q + 32'd1;
          wait_d   = 3'd0;
          stage_d  = STAGE_FETCH;
        end
      end
      STAGE_HALTED: begin
        // Absorbing; only reset leaves.
      end
      default: begin
        // Corrupted encoding: restart the fetch cycle cleanly, regardless of stall.
        stage_d  = STAGE_FETCH;
        wait_d   = 3'd0;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= STAGE_FETCH;
      wait_q   <= 3'd0;
      ir_q     <= 32'd0;
      count_q  <= 32'd0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      wait_q   <= wait_d;
      ir_q     <= ir_d;
      count_q  <= count_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  multicycle_stage_sequencer_pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_register (
    .clk      (clk),
    .rst      (rst),
    .en_i     (pc_en),
    .branch_i (bus.branch_taken),
    .target_i (bus.branch_target),
    .pc_o     (bus.PC_value)
  );

  assign bus.stage           = stage_q;
  assign bus.instruction_reg = ir_q;
  assign bus.retired_count   = count_q;
  assign bus.retire          = retire_q;
  assign bus.halted          = halted_q;

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Bench for multicycle_stage_sequencer. Three instances share one stimulus:
//   [0] MEM_LATENCY=1, RESET_PC=0   [1] MEM_LATENCY=2, RESET_PC=0
//   [2] MEM_LATENCY=3, RESET_PC=32'hFFFF_FFFC
// A per-instance reference model (remaining-cycles-in-stage view) is compared on every
// falling edge; directed tables and sequences are compared 1 ns after rising edges.
module tb_multicycle_stage_sequencer;
  import multicycle_stage_sequencer_pkg::*;

  localparam int unsigned NDut = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall;
  logic [31:0] rd;
  itype_t      itype;
  logic        br;
  logic [31:0] tgt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_t      stage_w [NDut];
  logic [31:0] pc_w    [NDut];
  logic [31:0] ir_w    [NDut];
  logic [31:0] cnt_w   [NDut];
  logic        ret_w   [NDut];
  logic        halt_w  [NDut];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    multicycle_stage_sequencer_if bus ();
    assign bus.stall              = stall;
    assign bus.read_data_0        = rd;
    assign bus.current_instr_type = itype;
    assign bus.branch_taken       = br;
    assign bus.branch_target      = tgt;

    multicycle_stage_sequencer #(
      .RESET_PC    ((g == 2) ? 32'hFFFF_FFFC : 32'h0000_0000),
      .MEM_LATENCY (g + 1),
      .PC_STEP     (32'd4)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign stage_w[g] = bus.stage;
    assign pc_w[g]    = bus.PC_value;
    assign ir_w[g]    = bus.instruction_reg;
    assign cnt_w[g]   = bus.retired_count;
    assign ret_w[g]   = bus.retire;
    assign halt_w[g]  = bus.halted;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lat_of(int k);
    return k + 1;
  endfunction

  function automatic logic [31:0] rpc_of(int k);
    return (k == 2) ? 32'hFFFF_FFFC : 32'h0000_0000;
  endfunction

  stage_t      m_stage [NDut];
  int          m_left  [NDut];
  logic [31:0] m_pc    [NDut];
  logic [31:0] m_ir    [NDut];
  logic        m_ret   [NDut];
  logic [31:0] m_cnt   [NDut];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NDut; k++) begin
      if (rst) begin
        m_stage[k] <= STAGE_FETCH;
        m_left[k]  <= lat_of(k);
        m_pc[k]    <= rpc_of(k);
        m_ir[k]    <= 32'd0;
        m_ret[k]   <= 1'b0;
        m_cnt[k]   <= 32'd0;
      end else begin
        m_ret[k] <= 1'b0;
        if (!stall) begin
          case (m_stage[k])
            STAGE_FETCH: begin
              if (m_left[k] == 1) begin
                m_ir[k]    <= rd;
                m_stage[k] <= STAGE_DECODE;
              end else begin
                m_left[k] <= m_left[k] - 1;
              end
            end
            STAGE_DECODE: m_stage[k] <= (itype == INSTR_HALT) ? STAGE_HALTED : STAGE_EXECUTE;
            STAGE_EXECUTE: begin
              m_left[k]  <= lat_of(k);
              m_stage[k] <= (itype == INSTR_LOAD || itype == INSTR_STORE) ? STAGE_MEMORY
                                                                          : STAGE_WRITEBACK;
            end
            STAGE_MEMORY: begin
              if (m_left[k] == 1) m_stage[k] <= STAGE_WRITEBACK;
              else m_left[k] <= m_left[k] - 1;
            end
            STAGE_WRITEBACK: begin
              m_pc[k]    <= br ? tgt : m_pc[k] + 32'd4;
              m_ret[k]   <= 1'b1;
              m_cnt[k]   <= m_cnt[k] + 32'd1;
              m_left[k]  <= lat_of(k);
              m_stage[k] <= STAGE_FETCH;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 0) begin
      for (int k = 0; k < NDut; k++) begin
        chk($sformatf("model_stage[%0d]", k), 32'(stage_w[k]), 32'(m_stage[k]));
        chk($sformatf("model_pc[%0d]", k), pc_w[k], m_pc[k]);
        chk($sformatf("model_ir[%0d]", k), ir_w[k], m_ir[k]);
        chk($sformatf("model_retire[%0d]", k), 32'(ret_w[k]), 32'(m_ret[k]));
        chk($sformatf("model_halted[%0d]", k), 32'(halt_w[k]),
            32'(m_stage[k] == STAGE_HALTED));
        chk($sformatf("model_count[%0d]", k), cnt_w[k], m_cnt[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic        stall;
    itype_t      itype;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] rd;
    stage_t      e_stage;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic        e_ret;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after a rising edge; pulses reset well before the falling edge.
  task automatic pulse_rst();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic idle_inputs(input itype_t t);
    stall = 1'b0;
    rd    = 32'd0;
    itype = t;
    br    = 1'b0;
    tgt   = 32'd0;
  endtask

  stage_t store_seq [7];
  itype_t rand_types [4];

  initial begin
    // Latency-1 instance; expectations are the state after each rising edge.
    tbl[0]  = '{0, INSTR_ALU,   0, 0,         32'h1111_0001, STAGE_DECODE,    0, 32'h1111_0001, 0, 0};
    tbl[1]  = '{0, INSTR_ALU,   0, 0,         0,             STAGE_EXECUTE,   0, 32'h1111_0001, 0, 0};
    tbl[2]  = '{0, INSTR_ALU,   0, 0,         0,             STAGE_WRITEBACK, 0, 32'h1111_0001, 0, 0};
    tbl[3]  = '{0, INSTR_ALU,   0, 0,         0,             STAGE_FETCH,     4, 32'h1111_0001, 1, 1};
    tbl[4]  = '{0, INSTR_ALU,   0, 0,         32'h2222_0002, STAGE_DECODE,    4, 32'h2222_0002, 0, 1};
    tbl[5]  = '{0, INSTR_STORE, 0, 0,         0,             STAGE_EXECUTE,   4, 32'h2222_0002, 0, 1};
    tbl[6]  = '{0, INSTR_STORE, 0, 0,         0,             STAGE_MEMORY,    4, 32'h2222_0002, 0, 1};
    tbl[7]  = '{0, INSTR_STORE, 0, 0,         0,             STAGE_WRITEBACK, 4, 32'h2222_0002, 0, 1};
    tbl[8]  = '{0, INSTR_ALU,   1, 32'h100,   0,             STAGE_FETCH,     32'h100, 32'h2222_0002, 1, 2};
    tbl[9]  = '{0, INSTR_ALU,   0, 0,         32'h3333_0003, STAGE_DECODE,    32'h100, 32'h3333_0003, 0, 2};
    tbl[10] = '{1, INSTR_HALT,  0, 0,         0,             STAGE_DECODE,    32'h100, 32'h3333_0003, 0, 2};
    tbl[11] = '{0, INSTR_LOAD,  0, 0,         0,             STAGE_EXECUTE,   32'h100, 32'h3333_0003, 0, 2};
    tbl[12] = '{0, INSTR_LOAD,  0, 0,         0,             STAGE_MEMORY,    32'h100, 32'h3333_0003, 0, 2};
    tbl[13] = '{1, INSTR_LOAD,  0, 0,         0,             STAGE_MEMORY,    32'h100, 32'h3333_0003, 0, 2};
    tbl[14] = '{0, INSTR_LOAD,  0, 0,         0,             STAGE_WRITEBACK, 32'h100, 32'h3333_0003, 0, 2};
    tbl[15] = '{1, INSTR_ALU,   1, 32'h500,   0,             STAGE_WRITEBACK, 32'h100, 32'h3333_0003, 0, 2};
    tbl[16] = '{0, INSTR_ALU,   0, 32'h500,   0,             STAGE_FETCH,     32'h104, 32'h3333_0003, 1, 3};

    store_seq = '{STAGE_FETCH, STAGE_DECODE, STAGE_EXECUTE, STAGE_MEMORY, STAGE_MEMORY,
                  STAGE_WRITEBACK, STAGE_FETCH};
    rand_types = '{INSTR_ALU, INSTR_LOAD, INSTR_STORE, INSTR_BRANCH};

    idle_inputs(INSTR_ALU);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < NDut; k++) begin
      chk("reset_stage", 32'(stage_w[k]), 32'(STAGE_FETCH));
      chk("reset_pc", pc_w[k], (k == 2) ? 32'hFFFF_FFFC : 32'h0);
      chk("reset_ir", ir_w[k], 32'h0);
      chk("reset_retire", 32'(ret_w[k]), 32'h0);
      chk("reset_halted", 32'(halt_w[k]), 32'h0);
      chk("reset_count", cnt_w[k], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table: basic flow, store, branch, stalls in several stages.
    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].stall;
      itype = tbl[i].itype;
      br    = tbl[i].br;
      tgt   = tbl[i].tgt;
      rd    = tbl[i].rd;
      tick();
      chk($sformatf("tbl%0d_stage", i), 32'(stage_w[0]), 32'(tbl[i].e_stage));
      chk($sformatf("tbl%0d_pc", i), pc_w[0], tbl[i].e_pc);
      chk($sformatf("tbl%0d_ir", i), ir_w[0], tbl[i].e_ir);
      chk($sformatf("tbl%0d_retire", i), 32'(ret_w[0]), 32'(tbl[i].e_ret));
      chk($sformatf("tbl%0d_count", i), cnt_w[0], tbl[i].e_cnt);
    end

    // Latency-3 fetch: only the word present on the third FETCH cycle is latched; then
    // the sequential PC step wraps 0xFFFF_FFFC -> 0.
    idle_inputs(INSTR_ALU);
    pulse_rst();
    rd = 32'h0BAD_0BAD;
    tick();
    chk("lat3_fetch1", 32'(stage_w[2]), 32'(STAGE_FETCH));
    rd = 32'h1234_5678;
    tick();
    chk("lat3_fetch2", 32'(stage_w[2]), 32'(STAGE_FETCH));
    rd = 32'hDEAD_BEEF;
    tick();
    chk("lat3_decode", 32'(stage_w[2]), 32'(STAGE_DECODE));
    chk("lat3_ir", ir_w[2], 32'hDEAD_BEEF);
    rd = 32'h0;
    tick();
    tick();
    chk("lat3_wb", 32'(stage_w[2]), 32'(STAGE_WRITEBACK));
    tick();
    chk("wrap_pc", pc_w[2], 32'h0);
    chk("wrap_retire", 32'(ret_w[2]), 32'h1);
    chk("wrap_count", cnt_w[2], 32'h1);

    // Latency-2 store: 2+1+1+2+1 = 7 cycles, retire only after the last.
    idle_inputs(INSTR_STORE);
    pulse_rst();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("store_stage%0d", i), 32'(stage_w[1]), 32'(store_seq[i]));
      chk($sformatf("store_retire%0d", i), 32'(ret_w[1]), (i == 6) ? 32'h1 : 32'h0);
    end

    // Five stalled WRITEBACK cycles, then the retire.
    idle_inputs(INSTR_ALU);
    pulse_rst();
    tick();
    tick();
    tick();
    chk("stallwb_enter", 32'(stage_w[0]), 32'(STAGE_WRITEBACK));
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stallwb_stage", 32'(stage_w[0]), 32'(STAGE_WRITEBACK));
      chk("stallwb_retire", 32'(ret_w[0]), 32'h0);
      chk("stallwb_pc", pc_w[0], 32'h0);
      chk("stallwb_count", cnt_w[0], 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("stallwb_release_retire", 32'(ret_w[0]), 32'h1);
    chk("stallwb_release_pc", pc_w[0], 32'h4);
    chk("stallwb_release_count", cnt_w[0], 32'h1);
    tick();
    chk("stallwb_pulse_width", 32'(ret_w[0]), 32'h0);

    // Halt: parks, ignores everything for 20 cycles, leaves only through async reset.
    idle_inputs(INSTR_HALT);
    pulse_rst();
    for (int i = 0; i < 4; i++) tick();
    chk("halt_stage0", 32'(stage_w[0]), 32'(STAGE_HALTED));
    chk("halt_flag2", 32'(halt_w[2]), 32'h1);
    for (int i = 0; i < 20; i++) begin
      stall = 1'($urandom_range(0, 1));
      rd    = $urandom;
      br    = 1'b1;
      tgt   = 32'h4000;
      itype = INSTR_ALU;
      tick();
      chk("halt_hold_stage", 32'(stage_w[0]), 32'(STAGE_HALTED));
      chk("halt_hold_flag", 32'(halt_w[0]), 32'h1);
      chk("halt_hold_pc", pc_w[0], 32'h0);
      chk("halt_hold_pc2", pc_w[2], 32'hFFFF_FFFC);
    end
    idle_inputs(INSTR_LOAD);
    #1 rst = 1'b1;
    #1;
    chk("halt_rst_stage", 32'(stage_w[0]), 32'(STAGE_FETCH));
    chk("halt_rst_flag", 32'(halt_w[0]), 32'h0);
    chk("halt_rst_pc2", pc_w[2], 32'hFFFF_FFFC);
    rst = 1'b0;

    // Reset inside MEMORY abandons the load.
    for (int i = 0; i < 6; i++) tick();
    chk("memrst_in_mem", 32'(stage_w[2]), 32'(STAGE_MEMORY));
    #1 rst = 1'b1;
    #1;
    chk("memrst_stage", 32'(stage_w[2]), 32'(STAGE_FETCH));
    chk("memrst_count", cnt_w[2], 32'h0);
    chk("memrst_pc", pc_w[2], 32'hFFFF_FFFC);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("memrst_no_retire", 32'(ret_w[2]), 32'h0);
    end

    // Random phase, checked by the model on every falling edge.
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      rd    = $urandom;
      itype = ($urandom_range(0, 39) == 0) ? INSTR_HALT : rand_types[$urandom_range(0, 3)];
      br    = 1'($urandom_range(0, 1));
      tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      if ($urandom_range(0, 119) == 0) pulse_rst();
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
